fill_sequencer: RTL

Run-time controller for one bottle-filling line: hopper gate, conveyor, pill counter and bottle counter.
- Takes targets from the settings front-end and sequences each bottle: advance → fill → settle → advance, until the batch completes.
- Watches the emergency stop, hopper-starved and conveyor-stall conditions.
- Drives the actuators and exposes binary counts/state for the display block.

---
 rtl/fill_sequencer_if.sv | 44 ++++
 rtl/fill_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fill_sequencer_if.sv
// Handshake/bus bundle between the settings front-end and the fill sequencer.
// master = front-end / display side, slave = fill_sequencer. pause exists only with PAUSE_EN.
interface fill_sequencer_if;
  logic       start;
  logic       estop;
  logic [9:0] target_pills;
  logic [6:0] target_bottles;
  logic       pill_pulse;
  logic       bottle_in_place;
  logic       hopper_empty;
  logic       ack_fault;
`ifdef PAUSE_EN
  logic       pause;
`endif
  logic       conveyor_run;
  logic       gate_open;
  logic [9:0] pill_count;
  logic [6:0] bottle_count;
  logic       bottle_done;
  logic       batch_done;
  logic       fault;
  logic [1:0] fault_code;
  logic [2:0] state;

  modport master (
`ifdef PAUSE_EN
    output pause,
`endif
    output start, estop, target_pills, target_bottles,
    output pill_pulse, bottle_in_place, hopper_empty, ack_fault,
    input  conveyor_run, gate_open, pill_count, bottle_count,
    input  bottle_done, batch_done, fault, fault_code, state
  );

  modport slave (
`ifdef PAUSE_EN
    input  pause,
`endif
    input  start, estop, target_pills, target_bottles,
    input  pill_pulse, bottle_in_place, hopper_empty, ack_fault,
    output conveyor_run, gate_open, pill_count, bottle_count,
    output bottle_done, batch_done, fault, fault_code, state
  );
endinterface

// File: rtl/fill_sequencer.sv
// Bottle-fill line sequencer: advance -> fill -> settle per bottle, with
// estop / hopper-starved / conveyor-stall faults. Ports: clk_1khz, clr
// (async active-high), bus (fill_sequencer_if.slave). Optional PAUSE_EN adds
// bus.pause which freezes ADVANCE/FILL with actuators off.
module fill_sequencer #(
  parameter int CONV_TIMEOUT   = 3000,
  parameter int HOPPER_TIMEOUT = 2000,
  parameter int SETTLE_CYC     = 50
) (
  input logic         clk_1khz,
  input logic         clr,
  fill_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADV    = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam int TW = 16;
  localparam logic [TW-1:0] CONV_LAST = TW'(CONV_TIMEOUT - 1);
  localparam logic [TW-1:0] HOP_LAST  = TW'(HOPPER_TIMEOUT - 1);
  localparam logic [TW-1:0] SET_LAST  = TW'(SETTLE_CYC - 1);

  logic [2:0]    st, st_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [9:0]    pc, pc_n, tp, tp_n;
  logic [6:0]    bc, bc_n, tb, tb_n;
  logic          seen, seen_n;
  logic [1:0]    code, code_n;
  logic          bdone_n;
  logic          conv_q, gate_q, bdone_q, batch_q, fault_q;
  logic          paused, go;
  logic [9:0]    pc_inc;
  logic [6:0]    bc_inc;

`ifdef PAUSE_EN
  assign paused = bus.pause;
`else
  assign paused = 1'b0;
`endif

  assign go = bus.start
           && (bus.target_pills   >= 10'd1) && (bus.target_pills   <= 10'd999)
           && (bus.target_bottles >= 7'd1)  && (bus.target_bottles <= 7'd99);

  assign pc_inc = pc + 10'd1;
  assign bc_inc = bc + 7'd1;

  always_comb begin
    st_n    = st;
    tmr_n   = tmr;
    pc_n    = pc;
    bc_n    = bc;
    tp_n    = tp;
    tb_n    = tb;
    seen_n  = seen;
    code_n  = code;
    bdone_n = 1'b0;
    if (bus.estop && st != S_ERROR) begin
      st_n   = S_ERROR;
      code_n = 2'd1;
    end else begin
      unique case (st)
        S_IDLE, S_DONE: begin
          if (go) begin
            tp_n   = bus.target_pills;
            tb_n   = bus.target_bottles;
            pc_n   = '0;
            bc_n   = '0;
            seen_n = 1'b1;
            tmr_n  = '0;
            st_n   = S_ADV;
          end
        end
        S_ADV: begin
          if (!paused) begin
            // entering FILL needs a fresh arrival, not a bottle left in place
            if (bus.bottle_in_place && seen) begin
              st_n  = S_FILL;
              tmr_n = '0;
            end else if (tmr == CONV_LAST) begin
              st_n   = S_ERROR;
              code_n = 2'd3;
            end else begin
              tmr_n = tmr + 1'b1;
              if (!bus.bottle_in_place) seen_n = 1'b1;
            end
          end
        end
        S_FILL: begin
          if (bus.pill_pulse) begin
            pc_n  = pc_inc;
            tmr_n = '0;
            if (pc_inc == tp) st_n = S_SETTLE;
          end else if (!paused) begin
            if (!bus.hopper_empty) begin
              tmr_n = '0;
            end else if (tmr == HOP_LAST) begin
              st_n   = S_ERROR;
              code_n = 2'd2;
            end else begin
              tmr_n = tmr + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (tmr == SET_LAST) begin
            bc_n    = bc_inc;
            bdone_n = 1'b1;
            pc_n    = '0;
            seen_n  = 1'b0;
            tmr_n   = '0;
            st_n    = (bc_inc == tb) ? S_DONE : S_ADV;
          end else begin
            tmr_n = tmr + 1'b1;
          end
        end
        S_ERROR: begin
          if (bus.ack_fault && !bus.estop) begin
            st_n   = S_IDLE;
            code_n = 2'd0;
            pc_n   = '0;
            bc_n   = '0;
            tmr_n  = '0;
          end
        end
        default: begin
          st_n  = S_IDLE;
          tmr_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1khz or posedge clr) begin
    if (clr) begin
      st      <= S_IDLE;
      tmr     <= '0;
      pc      <= '0;
      bc      <= '0;
      tp      <= 10'd1;
      tb      <= 7'd1;
      seen    <= 1'b0;
      code    <= 2'd0;
      conv_q  <= 1'b0;
      gate_q  <= 1'b0;
      bdone_q <= 1'b0;
      batch_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      st      <= st_n;
      tmr     <= tmr_n;
      pc      <= pc_n;
      bc      <= bc_n;
      tp      <= tp_n;
      tb      <= tb_n;
      seen    <= seen_n;
      code    <= code_n;
      conv_q  <= (st_n == S_ADV) && !paused;
      gate_q  <= (st_n == S_FILL) && !paused;
      bdone_q <= bdone_n;
      batch_q <= (st_n == S_DONE);
      fault_q <= (st_n == S_ERROR);
    end
  end

  assign bus.state        = st;
  assign bus.pill_count   = pc;
  assign bus.bottle_count = bc;
  assign bus.fault_code   = code;
  assign bus.conveyor_run = conv_q;
  assign bus.gate_open    = gate_q;
  assign bus.bottle_done  = bdone_q;
  assign bus.batch_done   = batch_q;
  assign bus.fault        = fault_q;

endmodule
